// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the asynchronous SRAM controller.
//   state_e            - FSM state encoding (IDLE, SETUP, ACCESS, HOLD)
//   ACCESS_CYCLES_DEF  - default number of cycles with we_n/oe_n asserted
//   ADDR_W / DATA_W    - SRAM word-address and data widths
package sram_pkg;

  localparam int ACCESS_CYCLES_DEF = 2;
  localparam int ADDR_W            = 18;
  localparam int DATA_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller.
// One transaction is IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> HOLD -> IDLE.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata- request: 1 = write, word address, write data
//   rsp_valid/rsp_rdata      - one-cycle read completion pulse, last read data
//   sram_cs_n/we_n/oe_n      - active-low SRAM strobes (all registered)
//   sram_addr/sram_dq_out    - SRAM address and write data
//   sram_dq_oe               - data bus drive enable for the pad at the top level
//   sram_dq_in               - data bus as seen from the SRAM
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                cs_n_q, cs_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;

  // Outputs for the coming state are computed here and registered, so the
  // SRAM pins never see a combinational path from the request side.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cs_n_d      = cs_n_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_SETUP;
          we_d    = req_we;
          cs_n_d  = 1'b0;
          addr_d  = req_addr;
          dq_oe_d = req_we;
          // Reads leave the last written data on dq_out; only the enable matters.
          if (req_we) dq_out_d = req_wdata;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
        we_n_d  = ~we_q;
        oe_n_d  = we_q;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          // Capture while oe_n is still low on this edge.
          if (!we_q) begin
            rsp_rdata_d = sram_dq_in;
            rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign sram_cs_n   = cs_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: sram_ctrl against a behavioural SRAM at 100 MHz, ACCESS_CYCLES = 2.
module tb_sram_ctrl;
  import sram_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_out, sram_dq_in;

  always #5 clk = ~clk;

  sram_ctrl #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in)
  );

  // SRAM chip model
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
  always @(posedge clk)
    if (!sram_cs_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;

  int n_total = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Invariant monitor
  int inv_viol = 0;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_dq;
  logic              p_we_n = 1'b1;
  always @(negedge clk) begin
    if (!sram_we_n && !sram_oe_n) inv_viol++;
    if (sram_dq_oe && !sram_oe_n) inv_viol++;
    if (!p_we_n && !sram_we_n && (p_addr != sram_addr || p_dq != sram_dq_out)) inv_viol++;
    p_we_n = sram_we_n; p_addr = sram_addr; p_dq = sram_dq_out;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Raise a request and return just after its handshake edge.
  task automatic handshake(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, output bit ok);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  // Full transaction with per-phase pin checks.
  task automatic txn(input vec_t v);
    bit ok;
    logic [3:0] pulses;
    handshake(v.we, v.addr, v.wdata, ok);
    if (!ok) return;
    // SETUP
    chk("setup_pins", {sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe, sram_addr},
        {1'b0, 1'b1, 1'b1, v.we, v.addr});
    if (v.we) chk("setup_dq", sram_dq_out, v.wdata);
    pulses = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      pulses[k-1] = rsp_valid;
      if (k == 1)
        chk("access_pins", {sram_cs_n, sram_we_n, sram_oe_n}, {1'b0, ~v.we, v.we});
    end
    chk("rsp_pulse", pulses, v.we ? 4'b0000 : 4'b0100);
    if (!v.we) chk("rdata", rsp_rdata, v.exp);
    chk("idle_pins", {req_ready, sram_cs_n, sram_dq_oe, sram_addr}, {1'b1, 1'b1, 1'b0, v.addr});
  endtask

  vec_t vecs[8];
  logic [DATA_W-1:0] bb_exp[2];
  int   hs_cyc[4];

  initial begin
    bit ok;
    int nh, nr, cyc;
    logic prev_ready;
    logic [3:0] pulses;

    vecs[0] = '{1'b1, 18'h00012, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 18'h00012, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 18'h3FFFF, 16'h1234, 16'h0000};
    vecs[3] = '{1'b1, 18'h00000, 16'h5678, 16'h0000};
    vecs[4] = '{1'b0, 18'h3FFFF, 16'h0000, 16'h1234};
    vecs[5] = '{1'b0, 18'h00000, 16'h0000, 16'h5678};
    vecs[6] = '{1'b1, 18'h2AAAA, 16'hA5A5, 16'h0000};
    vecs[7] = '{1'b0, 18'h2AAAA, 16'h0000, 16'hA5A5};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_pins", {req_ready, rsp_valid, sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe},
        6'b101110);
    chk("reset_data", {rsp_rdata, sram_dq_out}, 32'h0);
    chk("reset_addr", sram_addr, 18'h0);

    foreach (vecs[i]) txn(vecs[i]);

    // Back-to-back: req_valid held, write/read alternating.
    bb_exp[0] = 16'h1111; bb_exp[1] = 16'h2222;
    nh = 0; nr = 0; cyc = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00100; req_wdata = 16'h1111;
    for (int c = 0; c < 30; c++) begin
      prev_ready = req_ready;
      tick(); cyc++;
      if (prev_ready && req_valid) begin
        hs_cyc[nh] = cyc; nh++;
        case (nh)
          1: begin req_we = 1'b0; req_addr = 18'h00100; end
          2: begin req_we = 1'b1; req_addr = 18'h00101; req_wdata = 16'h2222; end
          3: begin req_we = 1'b0; req_addr = 18'h00101; end
          default: req_valid = 1'b0;
        endcase
      end
      if (rsp_valid) begin
        if (nr < 2) chk("b2b_rdata", rsp_rdata, bb_exp[nr]);
        nr++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_hs_count", nh, 4);
    chk("b2b_rsp_count", nr, 2);
    if (nh == 4)
      for (int i = 1; i < 4; i++) chk("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 5);

    // Reset in first ACCESS cycle of a read.
    handshake(1'b0, 18'h00012, 16'h0, ok);
    tick();
    chk("rst_mid_access_entered", {sram_cs_n, sram_oe_n}, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_pins", {sram_cs_n, sram_we_n, sram_oe_n, sram_dq_oe, rsp_valid}, 5'b11100);
    pulses = '0;
    for (int k = 0; k < 4; k++) begin tick(); pulses[k] = rsp_valid; end
    chk("rst_mid_no_rsp", pulses, 4'b0000);
    txn('{1'b0, 18'h00012, 16'h0, 16'hBEEF});

    // One-cycle req_valid pulse during ACCESS must be ignored.
    handshake(1'b1, 18'h00200, 16'h7777, ok);
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h00012;
    chk("pulse_ready_low", req_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("pulse_ready_low2", req_ready, 1'b0);
    tick(); tick();
    chk("pulse_back_idle", req_ready, 1'b1);
    pulses = '0;
    for (int k = 0; k < 4; k++) begin tick(); pulses[k] = sram_cs_n; end
    chk("pulse_no_second_txn", pulses, 4'b1111);
    txn('{1'b0, 18'h00200, 16'h0, 16'h7777});

    chk("invariants", inv_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
